// File: rtl/approx_err_monitor.sv
// approx_err_monitor: streaming error-metric collector for a DATA_W-bit approximate adder.
//
// Accepts (a, b, approx) samples over a valid/ready handshake, recomputes the exact sum and
// accumulates, over a programmed number of samples, the saturating sum of |approx-exact|, the
// largest error and the count of erroneous samples. The result is presented as one report
// record over a second valid/ready handshake.
//
// Optional feature: define ERRMON_BIAS_EN to add rpt_bias_sum, a saturating signed sum of
// (approx-exact) that is pipelined and reported alongside rpt_abs_sum.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, cfg_n          run start pulse (honoured in IDLE only) and samples per run
//   in_valid/in_ready     sample handshake; in_a, in_b operands, in_approx approximate sum
//   rpt_valid/rpt_ready   report handshake
//   rpt_abs_sum           saturating sum of |approx-exact|
//   rpt_max_err           largest |approx-exact| in the run
//   rpt_err_cnt           samples with nonzero error
//   rpt_samples           samples processed
//   busy                  high whenever not IDLE
//   rpt_bias_sum          (ERRMON_BIAS_EN only) saturating signed sum of (approx-exact)
module approx_err_monitor #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ACC_W  = 34
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [DATA_W:0]     in_approx,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [ACC_W-1:0]    rpt_abs_sum,
  output logic [DATA_W:0]     rpt_max_err,
  output logic [CNT_W-1:0]    rpt_err_cnt,
  output logic [CNT_W-1:0]    rpt_samples,
  output logic                busy
`ifdef ERRMON_BIAS_EN
  ,
  output logic signed [ACC_W:0] rpt_bias_sum
`endif
);

  localparam int unsigned SW = DATA_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StReport} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;

  logic             s1_valid_q;
  logic [SW-1:0]    s1_exact_q;
  logic [SW-1:0]    s1_approx_q;
  logic             s2_valid_q;
  logic [SW-1:0]    s2_err_q;

  logic [ACC_W-1:0] abs_q, abs_d;
  logic [SW-1:0]    max_q, max_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;

  logic             start_go;
  logic             accept;
  logic             last_accept;
  logic signed [SW:0] diff;
  logic [SW-1:0]    err;
  logic [ACC_W:0]   abs_wide;

  assign start_go    = (state_q == StIdle) && start;
  assign accept      = in_valid && in_ready_q;
  assign last_accept = accept && (cnt_q == n_q - CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = (cfg_n == '0) ? StReport : StRun;
      StRun:    if (last_accept) state_d = StDrain;
      StDrain:  if (!s1_valid_q && !s2_valid_q) state_d = StReport;
      StReport: if (rpt_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != StIdle);
    rpt_valid = (state_q == StReport);
    in_ready  = in_ready_q;
  end

  // Run control: in_ready is registered so it never depends combinationally on in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else if (start_go) begin
      n_q        <= cfg_n;
      cnt_q      <= '0;
      in_ready_q <= (cfg_n != '0);
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_accept) in_ready_q <= 1'b0;
    end
  end

  // Stage 1: exact sum alongside the approximate sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_exact_q  <= {1'b0, in_a} + {1'b0, in_b};
        s1_approx_q <= in_approx;
      end
    end
  end

  // Signed difference is one bit wider than the sums; its magnitude always fits in SW bits.
  always_comb begin
    diff = $signed({1'b0, s1_approx_q}) - $signed({1'b0, s1_exact_q});
    err  = diff[SW] ? SW'(-diff) : diff[SW-1:0];
  end

  // Stage 2: error magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_err_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_err_q <= err;
    end
  end

  // Accumulator next-state
  always_comb begin
    abs_wide = {1'b0, abs_q} + (ACC_W + 1)'(s2_err_q);
    abs_d    = abs_wide[ACC_W] ? {ACC_W{1'b1}} : abs_wide[ACC_W-1:0];
    max_d    = (s2_err_q > max_q) ? s2_err_q : max_q;
    errcnt_d = errcnt_q + CNT_W'(s2_err_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_q    <= '0;
      max_q    <= '0;
      errcnt_q <= '0;
    end else if (start_go) begin
      abs_q    <= '0;
      max_q    <= '0;
      errcnt_q <= '0;
    end else if (s2_valid_q) begin
      abs_q    <= abs_d;
      max_q    <= max_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Report fields are the accumulators themselves; they hold until the next start.
  assign rpt_abs_sum = abs_q;
  assign rpt_max_err = max_q;
  assign rpt_err_cnt = errcnt_q;
  assign rpt_samples = cnt_q;

`ifdef ERRMON_BIAS_EN
  logic signed [SW:0]      s2_diff_q;
  logic signed [ACC_W:0]   bias_q, bias_d;
  logic signed [ACC_W+1:0] bias_wide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_diff_q <= '0;
    end else if (s1_valid_q) begin
      s2_diff_q <= diff;
    end
  end

  // Overflow shows up as disagreement between the two top bits of the widened sum.
  always_comb begin
    bias_wide = {bias_q[ACC_W], bias_q} + {{(ACC_W + 1 - SW){s2_diff_q[SW]}}, s2_diff_q};
    if (bias_wide[ACC_W+1] != bias_wide[ACC_W]) begin
      bias_d = bias_wide[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
    end else begin
      bias_d = bias_wide[ACC_W:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q <= '0;
    end else if (start_go) begin
      bias_q <= '0;
    end else if (s2_valid_q) begin
      bias_q <= bias_d;
    end
  end

  assign rpt_bias_sum = bias_q;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Self-checking bench for approx_err_monitor: table of directed runs plus hand-written
// sequences for reset abort, report stall and accumulator saturation (ACC_W=17 instance).
module tb_approx_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, in_valid, rpt_ready;
  logic [15:0] cfg_n, in_a, in_b;
  logic [16:0] in_approx;
  logic        in_ready, rpt_valid, busy;
  logic [33:0] rpt_abs_sum;
  logic [16:0] rpt_max_err;
  logic [15:0] rpt_err_cnt, rpt_samples;

  // Second instance with a narrow accumulator for the saturation case
  logic        s_start, s_valid;
  logic [15:0] s_cfg, s_a, s_b;
  logic [16:0] s_ap;
  logic        s_in_ready, s_rpt_valid, s_busy;
  logic [16:0] s_abs;
  logic [16:0] s_max;
  logic [15:0] s_cnt, s_samples;

`ifdef ERRMON_BIAS_EN
  logic signed [34:0] rpt_bias_sum;
  logic signed [17:0] s_bias;
`endif

  approx_err_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_n      (cfg_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_approx  (in_approx),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_abs_sum(rpt_abs_sum),
    .rpt_max_err(rpt_max_err),
    .rpt_err_cnt(rpt_err_cnt),
    .rpt_samples(rpt_samples),
    .busy       (busy)
`ifdef ERRMON_BIAS_EN
    ,
    .rpt_bias_sum(rpt_bias_sum)
`endif
  );

  approx_err_monitor #(.ACC_W(17)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
    .cfg_n      (s_cfg),
    .in_valid   (s_valid),
    .in_ready   (s_in_ready),
    .in_a       (s_a),
    .in_b       (s_b),
    .in_approx  (s_ap),
    .rpt_valid  (s_rpt_valid),
    .rpt_ready  (1'b1),
    .rpt_abs_sum(s_abs),
    .rpt_max_err(s_max),
    .rpt_err_cnt(s_cnt),
    .rpt_samples(s_samples),
    .busy       (s_busy)
`ifdef ERRMON_BIAS_EN
    ,
    .rpt_bias_sum(s_bias)
`endif
  );

  typedef struct {
    int unsigned       n;
    bit                poke;   // pulse start mid-run (must be ignored)
    bit                stall;  // hold rpt_ready low for 5 cycles
    logic [7:0][15:0]  a;
    logic [7:0][15:0]  b;
    logic [7:0][16:0]  ap;
    logic [33:0]       exp_abs;
    logic [16:0]       exp_max;
    logic [15:0]       exp_cnt;
    longint            exp_bias;
  } run_t;

  localparam int NRUNS = 5;
  run_t runs[NRUNS];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic set_s(input int r, input int i, input int a, input int b, input int ap);
    runs[r].a[i]  = 16'(a);
    runs[r].b[i]  = 16'(b);
    runs[r].ap[i] = 17'(ap);
  endtask

  task automatic set_exp(input int r, input int n, input longint abs_v, input int max_v,
                         input int cnt_v, input longint bias_v);
    runs[r].n        = n;
    runs[r].poke     = 1'b0;
    runs[r].stall    = 1'b0;
    runs[r].exp_abs  = 34'(abs_v);
    runs[r].exp_max  = 17'(max_v);
    runs[r].exp_cnt  = 16'(cnt_v);
    runs[r].exp_bias = bias_v;
  endtask

  task automatic run_one(input int r);
    int unsigned n;
    bit          seen;
    n = runs[r].n;
    @(negedge clk);
    start = 1'b1;
    cfg_n = 16'(n);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) chk($sformatf("run%0d zero_lat", r), 64'(rpt_valid), 64'd1);
    else        chk($sformatf("run%0d busy", r), 64'(busy), 64'd1);
    for (int i = 0; i < int'(n); i++) begin
      in_valid  = 1'b1;
      in_a      = runs[r].a[i];
      in_b      = runs[r].b[i];
      in_approx = runs[r].ap[i];
      if (runs[r].poke && i == 1) begin
        start = 1'b1;
        cfg_n = 16'd1;
      end
      chk($sformatf("run%0d in_ready[%0d]", r, i), 64'(in_ready), 64'd1);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk($sformatf("run%0d ready_drop", r), 64'(in_ready), 64'd0);
    if (runs[r].stall) rpt_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (rpt_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("run%0d rpt_valid", r), 64'(seen), 64'd1);
    chk($sformatf("run%0d abs_sum", r), 64'(rpt_abs_sum), 64'(runs[r].exp_abs));
    chk($sformatf("run%0d max_err", r), 64'(rpt_max_err), 64'(runs[r].exp_max));
    chk($sformatf("run%0d err_cnt", r), 64'(rpt_err_cnt), 64'(runs[r].exp_cnt));
    chk($sformatf("run%0d samples", r), 64'(rpt_samples), 64'(n));
`ifdef ERRMON_BIAS_EN
    chk($sformatf("run%0d bias", r), 64'(longint'(rpt_bias_sum)), 64'(runs[r].exp_bias));
`endif
    if (runs[r].stall) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk($sformatf("run%0d stall_valid", r), 64'(rpt_valid), 64'd1);
        chk($sformatf("run%0d stall_abs", r), 64'(rpt_abs_sum), 64'(runs[r].exp_abs));
      end
      rpt_ready = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("run%0d valid_clear", r), 64'(rpt_valid), 64'd0);
    chk($sformatf("run%0d idle", r), 64'(busy), 64'd0);
    chk($sformatf("run%0d hold_abs", r), 64'(rpt_abs_sum), 64'(runs[r].exp_abs));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    start = 1'b0; cfg_n = '0; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0;
    rpt_ready = 1'b1;
    s_start = 1'b0; s_cfg = '0; s_valid = 1'b0; s_a = '0; s_b = '0; s_ap = '0;

    // Run 0: post-abort fresh run
    set_exp(0, 2, 6, 4, 2, 2);
    set_s(0, 0, 0, 0, 4);
    set_s(0, 1, 1, 1, 0);
    // Run 1: exact samples
    set_exp(1, 3, 0, 0, 0, 0);
    set_s(1, 0, 1, 2, 3);
    set_s(1, 1, 100, 200, 300);
    set_s(1, 2, 65535, 1, 65536);
    // Run 2: mixed errors, with a start pulse mid-run
    set_exp(2, 4, 7, 5, 3, 3);
    runs[2].poke = 1'b1;
    set_s(2, 0, 3, 5, 7);
    set_s(2, 1, 1, 1, 1);
    set_s(2, 2, 10, 10, 20);
    set_s(2, 3, 0, 0, 5);
    // Run 3: back-to-back 8 samples, report stalled
    set_exp(3, 8, 262154, 131071, 5, -6);
    runs[3].stall = 1'b1;
    set_s(3, 0, 0, 0, 0);
    set_s(3, 1, 1, 0, 3);
    set_s(3, 2, 65535, 65535, 131070);
    set_s(3, 3, 65535, 65535, 0);
    set_s(3, 4, 100, 0, 90);
    set_s(3, 5, 7, 8, 16);
    set_s(3, 6, 0, 0, 131071);
    set_s(3, 7, 5, 5, 10);
    // Run 4: zero-length run
    set_exp(4, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset rpt_valid", 64'(rpt_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset abs_sum", 64'(rpt_abs_sum), 64'd0);
    rst_n = 1'b1;

    // Abort a run after 5 erroneous samples
    @(negedge clk);
    start = 1'b1;
    cfg_n = 16'd10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 16'd1; in_b = 16'd0; in_approx = 17'd9;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", 64'(in_ready), 64'd0);
    chk("abort rpt_valid", 64'(rpt_valid), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort abs_sum", 64'(rpt_abs_sum), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < NRUNS; r++) run_one(r);

    // Saturation on the ACC_W=17 instance: three samples of error 131071
    @(negedge clk);
    s_start = 1'b1;
    s_cfg   = 16'd3;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_a = '0; s_b = '0; s_ap = 17'd131071;
      chk("sat in_ready", 64'(s_in_ready), 64'd1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (s_rpt_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk("sat rpt_valid", 64'(seen), 64'd1);
    chk("sat abs_sum", 64'(s_abs), 64'd131071);
    chk("sat max_err", 64'(s_max), 64'd131071);
    chk("sat err_cnt", 64'(s_cnt), 64'd3);
    chk("sat samples", 64'(s_samples), 64'd3);
`ifdef ERRMON_BIAS_EN
    chk("sat bias", 64'(longint'(s_bias)), 64'd131071);
`endif
    @(negedge clk);
    chk("sat idle", 64'(s_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
